// File: rtl/logic_pair_cfg_loader_if.sv
// Serial configuration stream plus the programming outputs that feed one logic_pair cell.
interface logic_pair_cfg_loader_if;
    logic        cfg_din;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] look_up_t;
    logic        switch;
    logic        bypass;
    logic [2:0]  CYMUX0_select;
    logic        carryOut_sel_mux;
    logic        prgm_b;
    logic        CLB_prgm_b;
    logic        cfg_done;
    logic        cfg_err;

    modport master (
        output cfg_din, cfg_valid,
        input  cfg_ready, look_up_t, switch, bypass, CYMUX0_select, carryOut_sel_mux,
        input  prgm_b, CLB_prgm_b, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_din, cfg_valid,
        output cfg_ready, look_up_t, switch, bypass, CYMUX0_select, carryOut_sel_mux,
        output prgm_b, CLB_prgm_b, cfg_done, cfg_err
    );
endinterface

// File: rtl/logic_pair_cfg_loader.sv
// Framed serial loader for one logic pair: sync hunt, 22-bit payload, even parity,
// then a timed low-active programming strobe while the new config is held stable.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_HUNT   | shifting accepted bits looking for SYNC_WORD
//  S_LOAD   | writing payload bits LSB first into the shadow register
//  S_PARITY | next accepted bit is the even-parity bit
//  S_COMMIT | strobes low, input stalled, counting down PRG_CYCLES
module logic_pair_cfg_loader #(
    parameter logic [7:0]  SYNC_WORD  = 8'hA5,
    parameter int unsigned PRG_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    logic_pair_cfg_loader_if.slave   cfg
);
    localparam logic [3:0] PRG_LOAD = 4'(PRG_CYCLES);
    localparam logic [4:0] LAST_BIT = 5'd21;

    typedef enum logic [1:0] {S_HUNT, S_LOAD, S_PARITY, S_COMMIT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_sync_sr;
    logic [4:0]  r_bit_cnt;
    logic [21:0] r_shadow;
    logic [21:0] r_active;
    logic [3:0]  r_strobe_cnt;
    logic        r_done;
    logic        r_err;

    logic        w_ready;
    logic        w_accept;
    logic [7:0]  w_sync_nxt;
    logic        w_sync_hit;
    logic        w_parity_ok;
    logic        w_commit;
    logic        w_fail;
    logic        w_strobe_end;

    assign w_ready     = (r_state != S_COMMIT);
    assign w_accept    = cfg.cfg_valid & w_ready;
    assign w_sync_nxt  = {r_sync_sr[6:0], cfg.cfg_din};
    assign w_sync_hit  = (w_sync_nxt == SYNC_WORD);
    assign w_parity_ok = ~(^{r_shadow, cfg.cfg_din});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_commit     = 1'b0;
        w_fail       = 1'b0;
        w_strobe_end = 1'b0;
        case (r_state)
            S_HUNT: begin
                if (w_accept && w_sync_hit) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept && (r_bit_cnt == LAST_BIT)) begin
                    w_state_nxt = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_accept) begin
                    if (w_parity_ok) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_COMMIT;
                    end else begin
                        w_fail      = 1'b1;
                        w_state_nxt = S_HUNT;
                    end
                end
            end
            S_COMMIT: begin
                // counter value 1 decrements to 0 on this edge
                if (r_strobe_cnt <= 4'd1) begin
                    w_strobe_end = 1'b1;
                    w_state_nxt  = S_HUNT;
                end
            end
            default: begin
                w_state_nxt = S_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_sr    <= 8'h00;
            r_bit_cnt    <= 5'd0;
            r_shadow     <= 22'd0;
            r_active     <= 22'd0;
            r_strobe_cnt <= 4'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= w_strobe_end;
            r_err  <= w_fail;
            case (r_state)
                S_HUNT: begin
                    if (w_accept) begin
                        r_sync_sr <= w_sync_nxt;
                        if (w_sync_hit) begin
                            r_bit_cnt <= 5'd0;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_shadow[r_bit_cnt] <= cfg.cfg_din;
                        r_bit_cnt           <= r_bit_cnt + 5'd1;
                    end
                end
                S_PARITY: begin
                    if (w_commit) begin
                        r_active     <= r_shadow;
                        r_strobe_cnt <= PRG_LOAD;
                    end
                    if (w_fail) begin
                        r_sync_sr <= 8'h00;
                    end
                end
                S_COMMIT: begin
                    r_strobe_cnt <= r_strobe_cnt - 4'd1;
                    if (w_strobe_end) begin
                        r_sync_sr <= 8'h00;
                    end
                end
                default: begin
                    r_sync_sr <= 8'h00;
                end
            endcase
        end
    end

    assign cfg.cfg_ready        = w_ready;
    assign cfg.look_up_t        = r_active[15:0];
    assign cfg.switch           = r_active[16];
    assign cfg.bypass           = r_active[17];
    assign cfg.CYMUX0_select    = r_active[20:18];
    assign cfg.carryOut_sel_mux = r_active[21];
    assign cfg.prgm_b           = (r_state != S_COMMIT);
    assign cfg.CLB_prgm_b       = (r_state != S_COMMIT);
    assign cfg.cfg_done         = r_done;
    assign cfg.cfg_err          = r_err;
endmodule

// File: tb/tb_logic_pair_cfg_loader.sv
// Directed bench for logic_pair_cfg_loader with PRG_CYCLES = 2 and sync word A5.
module tb_logic_pair_cfg_loader;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    logic [7:0] sync_word = 8'hA5;

    logic_pair_cfg_loader_if u_if ();

    logic_pair_cfg_loader #(.SYNC_WORD(8'hA5), .PRG_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .cfg   (u_if)
    );

    always #5 clk = ~clk;

    // one clock: inputs change at negedge, return 1 time unit after the rising edge
    task automatic cyc(input logic v, input logic d);
        @(negedge clk);
        u_if.cfg_valid = v;
        u_if.cfg_din   = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] mk(input logic [15:0] lut, input logic sw, input logic byp,
                                       input logic [2:0] cy, input logic cm);
        return {cm, cy, byp, sw, lut};
    endfunction

    task automatic send_sync(input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            cyc(1'b1, sync_word[i]);
            if (gaps) cyc(1'b0, 1'b0);
        end
    endtask

    task automatic send_payload(input logic [21:0] p, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, p[k]);
            if (gaps) cyc(1'b0, 1'b0);
        end
    endtask

    // ends in the cycle right after the parity bit was accepted
    task automatic send_frame(input logic [21:0] p, input logic flip, input bit gaps);
        send_sync(gaps);
        send_payload(p, 22, gaps);
        cyc(1'b1, (^p) ^ flip);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (u_if.cfg_ready === 1'b1 && u_if.prgm_b === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc(1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        reset = 1'b0;
        total++; if (u_if.look_up_t !== 16'h0000) begin bad++; $display("FAIL reset_lut: got %h want 0000", u_if.look_up_t); end
        total++; if ({u_if.switch, u_if.bypass, u_if.CYMUX0_select, u_if.carryOut_sel_mux} !== 6'b0) begin bad++; $display("FAIL reset_fields: got %b want 000000", {u_if.switch, u_if.bypass, u_if.CYMUX0_select, u_if.carryOut_sel_mux}); end
        total++; if ({u_if.prgm_b, u_if.CLB_prgm_b} !== 2'b11) begin bad++; $display("FAIL reset_prgm: got %b want 11", {u_if.prgm_b, u_if.CLB_prgm_b}); end
        total++; if (u_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", u_if.cfg_ready); end
        total++; if ({u_if.cfg_done, u_if.cfg_err} !== 2'b00) begin bad++; $display("FAIL reset_done_err: got %b want 00", {u_if.cfg_done, u_if.cfg_err}); end
    endtask

    task automatic test_basic_load();
        send_frame(mk(16'h8000, 1'b1, 1'b0, 3'b000, 1'b0), 1'b0, 1'b0);
        total++; if (u_if.look_up_t !== 16'h8000) begin bad++; $display("FAIL basic_lut: got %h want 8000", u_if.look_up_t); end
        total++; if (u_if.switch !== 1'b1) begin bad++; $display("FAIL basic_switch: got %b want 1", u_if.switch); end
        total++; if ({u_if.prgm_b, u_if.CLB_prgm_b, u_if.cfg_ready, u_if.cfg_done} !== 4'b0000) begin bad++; $display("FAIL basic_strobe1: got %b want 0000", {u_if.prgm_b, u_if.CLB_prgm_b, u_if.cfg_ready, u_if.cfg_done}); end
        cyc(1'b0, 1'b0);
        total++; if ({u_if.prgm_b, u_if.CLB_prgm_b, u_if.cfg_done} !== 3'b000) begin bad++; $display("FAIL basic_strobe2: got %b want 000", {u_if.prgm_b, u_if.CLB_prgm_b, u_if.cfg_done}); end
        total++; if (u_if.look_up_t !== 16'h8000) begin bad++; $display("FAIL basic_lut_stable: got %h want 8000", u_if.look_up_t); end
        cyc(1'b0, 1'b0);
        total++; if ({u_if.prgm_b, u_if.CLB_prgm_b, u_if.cfg_ready, u_if.cfg_done} !== 4'b1111) begin bad++; $display("FAIL basic_done: got %b want 1111", {u_if.prgm_b, u_if.CLB_prgm_b, u_if.cfg_ready, u_if.cfg_done}); end
        cyc(1'b0, 1'b0);
        total++; if ({u_if.prgm_b, u_if.cfg_done} !== 2'b10) begin bad++; $display("FAIL basic_done_pulse: got %b want 10", {u_if.prgm_b, u_if.cfg_done}); end
    endtask

    task automatic test_parity_fail();
        bit ok;
        send_frame(mk(16'h00FF, 1'b0, 1'b0, 3'b000, 1'b0), 1'b0, 1'b0);
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL parity_pre_idle: got timeout want idle"); end
        total++; if (u_if.look_up_t !== 16'h00FF) begin bad++; $display("FAIL parity_pre_lut: got %h want 00ff", u_if.look_up_t); end
        send_frame(mk(16'h8000, 1'b1, 1'b0, 3'b000, 1'b0), 1'b1, 1'b0);
        total++; if (u_if.cfg_err !== 1'b1) begin bad++; $display("FAIL parity_err: got %b want 1", u_if.cfg_err); end
        total++; if (u_if.look_up_t !== 16'h00FF || u_if.switch !== 1'b0) begin bad++; $display("FAIL parity_hold: got %h/%b want 00ff/0", u_if.look_up_t, u_if.switch); end
        total++; if ({u_if.prgm_b, u_if.cfg_ready, u_if.cfg_done} !== 3'b110) begin bad++; $display("FAIL parity_state: got %b want 110", {u_if.prgm_b, u_if.cfg_ready, u_if.cfg_done}); end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0);
            total++; if ({u_if.prgm_b, u_if.CLB_prgm_b, u_if.cfg_err} !== 3'b110) begin bad++; $display("FAIL parity_after%0d: got %b want 110", i, {u_if.prgm_b, u_if.CLB_prgm_b, u_if.cfg_err}); end
        end
    endtask

    task automatic test_sync_gaps();
        bit ok;
        cyc(1'b1, 1'b1); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
        send_frame(mk(16'h0000, 1'b0, 1'b1, 3'b101, 1'b1), 1'b0, 1'b1);
        total++; if (u_if.prgm_b !== 1'b0) begin bad++; $display("FAIL gaps_strobe: got %b want 0", u_if.prgm_b); end
        total++; if ({u_if.carryOut_sel_mux, u_if.CYMUX0_select, u_if.bypass, u_if.switch} !== 6'b110110) begin bad++; $display("FAIL gaps_fields: got %b want 110110", {u_if.carryOut_sel_mux, u_if.CYMUX0_select, u_if.bypass, u_if.switch}); end
        total++; if (u_if.look_up_t !== 16'h0000) begin bad++; $display("FAIL gaps_lut: got %h want 0000", u_if.look_up_t); end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL gaps_idle: got timeout want idle"); end
    endtask

    task automatic test_backpressure();
        send_frame(mk(16'h0F0F, 1'b0, 1'b0, 3'b000, 1'b0), 1'b0, 1'b0);
        total++; if (u_if.cfg_ready !== 1'b0) begin bad++; $display("FAIL bp_ready1: got %b want 0", u_if.cfg_ready); end
        cyc(1'b1, 1'b1);
        total++; if (u_if.cfg_ready !== 1'b0) begin bad++; $display("FAIL bp_ready2: got %b want 0", u_if.cfg_ready); end
        cyc(1'b1, 1'b0);
        total++; if ({u_if.cfg_ready, u_if.cfg_done} !== 2'b11) begin bad++; $display("FAIL bp_ready_up: got %b want 11", {u_if.cfg_ready, u_if.cfg_done}); end
        total++; if (u_if.look_up_t !== 16'h0F0F) begin bad++; $display("FAIL bp_lut1: got %h want 0f0f", u_if.look_up_t); end
        send_frame(mk(16'h3C3C, 1'b0, 1'b0, 3'b000, 1'b0), 1'b0, 1'b0);
        total++; if (u_if.look_up_t !== 16'h3C3C || u_if.prgm_b !== 1'b0) begin bad++; $display("FAIL bp_lut2: got %h/%b want 3c3c/0", u_if.look_up_t, u_if.prgm_b); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_idle0: got timeout want idle"); end
        send_sync(1'b0);
        send_payload(mk(16'hFFFF, 1'b1, 1'b1, 3'b111, 1'b1), 10, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        reset = 1'b0;
        total++; if (u_if.look_up_t !== 16'h0000) begin bad++; $display("FAIL rmid_load_lut: got %h want 0000", u_if.look_up_t); end
        total++; if ({u_if.prgm_b, u_if.cfg_ready, u_if.cfg_done, u_if.cfg_err} !== 4'b1100) begin bad++; $display("FAIL rmid_load_ctl: got %b want 1100", {u_if.prgm_b, u_if.cfg_ready, u_if.cfg_done, u_if.cfg_err}); end
        send_frame(mk(16'hC3C3, 1'b0, 1'b0, 3'b011, 1'b0), 1'b0, 1'b0);
        total++; if (u_if.look_up_t !== 16'hC3C3 || u_if.CYMUX0_select !== 3'b011) begin bad++; $display("FAIL rmid_reload: got %h/%b want c3c3/011", u_if.look_up_t, u_if.CYMUX0_select); end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_idle1: got timeout want idle"); end
        send_frame(mk(16'h0001, 1'b0, 1'b0, 3'b000, 1'b0), 1'b0, 1'b0);
        total++; if (u_if.prgm_b !== 1'b0) begin bad++; $display("FAIL rmid_in_commit: got %b want 0", u_if.prgm_b); end
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        reset = 1'b0;
        total++; if ({u_if.prgm_b, u_if.CLB_prgm_b, u_if.cfg_ready} !== 3'b111) begin bad++; $display("FAIL rmid_commit_ctl: got %b want 111", {u_if.prgm_b, u_if.CLB_prgm_b, u_if.cfg_ready}); end
        total++; if (u_if.look_up_t !== 16'h0000) begin bad++; $display("FAIL rmid_commit_lut: got %h want 0000", u_if.look_up_t); end
        cyc(1'b0, 1'b0);
        total++; if ({u_if.prgm_b, u_if.cfg_done} !== 2'b10) begin bad++; $display("FAIL rmid_no_done: got %b want 10", {u_if.prgm_b, u_if.cfg_done}); end
        send_frame(mk(16'h7E00, 1'b1, 1'b0, 3'b000, 1'b1), 1'b0, 1'b0);
        total++; if ({u_if.look_up_t, u_if.switch, u_if.carryOut_sel_mux} !== {16'h7E00, 2'b11}) begin bad++; $display("FAIL rmid_final: got %h/%b%b want 7e00/11", u_if.look_up_t, u_if.switch, u_if.carryOut_sel_mux); end
    endtask

    task automatic test_payload_sync();
        bit ok;
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL psync_idle0: got timeout want idle"); end
        send_frame(mk(16'hA5A5, 1'b0, 1'b0, 3'b000, 1'b0), 1'b0, 1'b0);
        total++; if (u_if.look_up_t !== 16'hA5A5 || u_if.prgm_b !== 1'b0) begin bad++; $display("FAIL psync_lut: got %h/%b want a5a5/0", u_if.look_up_t, u_if.prgm_b); end
        total++; if (u_if.cfg_err !== 1'b0) begin bad++; $display("FAIL psync_err: got %b want 0", u_if.cfg_err); end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL psync_idle1: got timeout want idle"); end
        send_frame(mk(16'h1234, 1'b0, 1'b0, 3'b000, 1'b0), 1'b0, 1'b0);
        total++; if (u_if.look_up_t !== 16'h1234 || u_if.prgm_b !== 1'b0) begin bad++; $display("FAIL psync_second: got %h/%b want 1234/0", u_if.look_up_t, u_if.prgm_b); end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL psync_idle2: got timeout want idle"); end
    endtask

    initial begin
        reset          = 1'b1;
        u_if.cfg_valid = 1'b0;
        u_if.cfg_din   = 1'b0;
        test_reset();
        test_basic_load();
        test_parity_fail();
        test_sync_gaps();
        test_backpressure();
        test_reset_mid();
        test_payload_sync();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
